// File: rtl/arb_pkg.sv
// Shared helpers for the round-robin arbiter: index width sizing, isolation of
// the lowest set bit, and the lock state encoding.
package arb_pkg;

  // Widest request vector that lowest_set_oh can handle.
  localparam int MaxReq = 64;

  typedef enum logic {
    LockOpen = 1'b0,
    LockHeld = 1'b1
  } lock_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [MaxReq-1:0] lowest_set_oh(input logic [MaxReq-1:0] vec);
    return vec & (~vec + MaxReq'(1));
  endfunction

endpackage

// File: rtl/rr_arbiter_oh_if.sv
// Request/grant bundle between the requesters, the arbiter and the downstream stage.
// Valid/ready: a transfer happens in a cycle where gnt_valid_o && gnt_ready_i; the
// granted requester sees req_ready_o high in that same cycle and nowhere else.
interface rr_arbiter_oh_if
  import arb_pkg::*;
#(
  parameter int NumReq = 8
);
  localparam int IdxWidth = idx_width(NumReq);

  logic [NumReq-1:0]   req_valid_i;
  logic [NumReq-1:0]   req_ready_o;
  logic                gnt_valid_o;
  logic                gnt_ready_i;
  logic [NumReq-1:0]   gnt_oh_o;
  logic [IdxWidth-1:0] gnt_idx_o;

  modport slave (
    input  req_valid_i,
    input  gnt_ready_i,
    output req_ready_o,
    output gnt_valid_o,
    output gnt_oh_o,
    output gnt_idx_o
  );

  modport master (
    output req_valid_i,
    output gnt_ready_i,
    input  req_ready_o,
    input  gnt_valid_o,
    input  gnt_oh_o,
    input  gnt_idx_o
  );

endinterface

// File: rtl/oh2uint.sv
// One-hot to binary index encoder; an all-zero input encodes to 0.
module oh2uint
  import arb_pkg::*;
#(
  parameter int NumReq   = 8,
  parameter int IdxWidth = idx_width(NumReq)
) (
  input  logic [NumReq-1:0]   oh,
  output logic [IdxWidth-1:0] idx
);

  always_comb begin
    idx = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (oh[i]) idx = idx | IdxWidth'(i);
    end
  end

endmodule

// File: rtl/rr_prio_pick.sv
// Masked priority pick: lowest requester at or above ptr, falling back to the
// lowest requester overall when nothing sits at or above ptr. Purely combinational.
module rr_prio_pick
  import arb_pkg::*;
#(
  parameter int NumReq   = 8,
  parameter int IdxWidth = idx_width(NumReq)
) (
  input  logic [NumReq-1:0]   req,
  input  logic [IdxWidth-1:0] ptr,
  output logic [NumReq-1:0]   winner_oh
);

  logic [NumReq-1:0] mask;
  logic [NumReq-1:0] masked;
  logic [NumReq-1:0] pick;
  logic [MaxReq-1:0] ext;
  logic [MaxReq-1:0] low;

  always_comb begin
    mask = '0;
    for (int i = 0; i < NumReq; i++) begin
      mask[i] = (IdxWidth'(i) >= ptr);
    end
  end

  assign masked = req & mask;
  assign pick   = (|masked) ? masked : req;

  always_comb begin
    ext             = '0;
    ext[NumReq-1:0] = pick;
  end

  assign low       = lowest_set_oh(ext);
  assign winner_oh = low[NumReq-1:0];

  if (NumReq < MaxReq) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^low[MaxReq-1:NumReq];
  end

endmodule

// File: rtl/rr_arbiter_oh.sv
// N-input round-robin arbiter with a one-hot grant plus binary index. A grant that
// stalls downstream is locked so the one-hot vector stays put until it is taken.
module rr_arbiter_oh
  import arb_pkg::*;
#(
  parameter int NumReq    = 8,
  parameter bit LockGrant = 1'b1,
  localparam int IdxWidth = idx_width(NumReq)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  rr_arbiter_oh_if.slave      bus,
  output logic [IdxWidth-1:0] dbg_ptr,
  output lock_e               dbg_state,
  output logic [NumReq-1:0]   dbg_lock_oh
);

  logic [IdxWidth-1:0] ptr_q;
  lock_e               state_q;
  logic                lock_q;
  logic [NumReq-1:0]   lock_oh_q;

  logic [NumReq-1:0]   req_valid;
  logic                gnt_ready;
  logic [NumReq-1:0]   pick_oh;
  logic [NumReq-1:0]   gnt_oh;
  logic                gnt_valid;
  logic [IdxWidth-1:0] gnt_idx;
  logic                hs;

  assign req_valid = bus.req_valid_i;
  assign gnt_ready = bus.gnt_ready_i;
  assign lock_q    = (state_q == LockHeld);

  rr_prio_pick #(
    .NumReq   (NumReq),
    .IdxWidth (IdxWidth)
  ) u_pick (
    .req       (req_valid),
    .ptr       (ptr_q),
    .winner_oh (pick_oh)
  );

  // While locked only the held requester can be granted; if it drops, nothing is.
  assign gnt_oh    = lock_q ? (lock_oh_q & req_valid) : pick_oh;
  assign gnt_valid = |gnt_oh;
  assign hs        = gnt_valid && gnt_ready;

  oh2uint #(
    .NumReq   (NumReq),
    .IdxWidth (IdxWidth)
  ) u_enc (
    .oh  (gnt_oh),
    .idx (gnt_idx)
  );

  assign bus.gnt_oh_o    = gnt_oh;
  assign bus.gnt_valid_o = gnt_valid;
  assign bus.gnt_idx_o   = gnt_idx;
  assign bus.req_ready_o = gnt_oh & {NumReq{gnt_ready}};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else if (hs) begin
      ptr_q <= (gnt_idx == IdxWidth'(NumReq - 1)) ? '0 : gnt_idx + IdxWidth'(1);
    end
  end

  if (LockGrant) begin : g_lock
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state_q   <= LockOpen;
        lock_oh_q <= '0;
      end else begin
        case (state_q)
          LockOpen: begin
            if (gnt_valid && !gnt_ready) begin
              state_q   <= LockHeld;
              lock_oh_q <= gnt_oh;
            end
          end
          LockHeld: begin
            // Released by the handshake, or by the held requester withdrawing.
            if (hs || !gnt_valid) begin
              state_q   <= LockOpen;
              lock_oh_q <= '0;
            end
          end
          default: begin
            state_q   <= LockOpen;
            lock_oh_q <= '0;
          end
        endcase
      end
    end

    assert property (@(posedge clk_i) disable iff (!rst_ni)
      (gnt_valid && !gnt_ready) |=> (!gnt_valid || (gnt_oh == $past(gnt_oh))));
  end else begin : g_nolock
    assign state_q   = LockOpen;
    assign lock_oh_q = '0;
  end

  assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(gnt_oh));
  assert property (@(posedge clk_i) disable iff (!rst_ni) gnt_valid == (|gnt_oh));

  assign dbg_ptr     = ptr_q;
  assign dbg_state   = state_q;
  assign dbg_lock_oh = lock_oh_q;

endmodule

// File: tb/tb_rr_arbiter_oh.sv
// Directed bench for rr_arbiter_oh: an 8-requester locking instance and a
// single-requester instance, checked against hand-computed grants.
module tb_rr_arbiter_oh;
  import arb_pkg::*;

  logic clk;
  logic rst_ni;
  int   checks;
  int   errors;

  rr_arbiter_oh_if #(.NumReq(8)) bus ();
  rr_arbiter_oh_if #(.NumReq(1)) bus1 ();

  logic [2:0] dbg_ptr;
  lock_e      dbg_state;
  logic [7:0] dbg_lock_oh;
  logic [0:0] dbg_ptr1;
  lock_e      dbg_state1;
  logic [0:0] dbg_lock_oh1;

  rr_arbiter_oh #(.NumReq(8), .LockGrant(1'b1)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .bus         (bus.slave),
    .dbg_ptr     (dbg_ptr),
    .dbg_state   (dbg_state),
    .dbg_lock_oh (dbg_lock_oh)
  );

  rr_arbiter_oh #(.NumReq(1), .LockGrant(1'b1)) dut1 (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .bus         (bus1.slave),
    .dbg_ptr     (dbg_ptr1),
    .dbg_state   (dbg_state1),
    .dbg_lock_oh (dbg_lock_oh1)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks: all stimulus changes land 1 ns after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] req, input logic rdy);
    bus.req_valid_i = req;
    bus.gnt_ready_i = rdy;
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    drive(8'h00, 1'b0);
    bus1.req_valid_i = 1'b0;
    bus1.gnt_ready_i = 1'b0;
    step();
    step();
    checks++;
    if (bus.gnt_valid_o !== 1'b0 || bus.gnt_oh_o !== 8'h00 || bus.gnt_idx_o !== 3'd0 ||
        bus.req_ready_o !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs valid=%b oh=%h idx=%0d rdy=%h required 0 00 0 00",
               bus.gnt_valid_o, bus.gnt_oh_o, bus.gnt_idx_o, bus.req_ready_o);
    end
    checks++;
    if (dbg_ptr !== 3'd0 || dbg_state !== LockOpen) begin
      errors++;
      $display("FAIL reset_state ptr=%0d lock=%0d required 0 0", dbg_ptr, dbg_state);
    end
    rst_ni = 1'b1;
    step();
  endtask

  task automatic test_rotate();
    logic [7:0] exp_oh;
    drive(8'hFF, 1'b1);
    for (int k = 0; k < 8; k++) begin
      exp_oh = 8'h01 << k;
      checks++;
      if (bus.gnt_idx_o !== 3'(k) || bus.gnt_oh_o !== exp_oh || bus.req_ready_o !== exp_oh ||
          bus.gnt_valid_o !== 1'b1) begin
        errors++;
        $display("FAIL rotate_%0d idx=%0d oh=%h rdy=%h required idx=%0d oh=%h rdy=%h",
                 k, bus.gnt_idx_o, bus.gnt_oh_o, bus.req_ready_o, k, exp_oh, exp_oh);
      end
      step();
    end
    checks++;
    if (bus.gnt_idx_o !== 3'd0 || bus.gnt_oh_o !== 8'h01) begin
      errors++;
      $display("FAIL rotate_wrap idx=%0d oh=%h required 0 01", bus.gnt_idx_o, bus.gnt_oh_o);
    end
    step();
  endtask

  task automatic test_fallback();
    drive(8'h04, 1'b1);
    checks++;
    if (bus.gnt_idx_o !== 3'd2) begin
      errors++;
      $display("FAIL fallback_setup idx=%0d required 2", bus.gnt_idx_o);
    end
    step();
    checks++;
    if (dbg_ptr !== 3'd3) begin
      errors++;
      $display("FAIL fallback_ptr3 ptr=%0d required 3", dbg_ptr);
    end
    drive(8'h05, 1'b1);
    checks++;
    if (bus.gnt_idx_o !== 3'd0 || bus.gnt_oh_o !== 8'h01 || bus.req_ready_o !== 8'h01) begin
      errors++;
      $display("FAIL fallback_pick idx=%0d oh=%h rdy=%h required 0 01 01",
               bus.gnt_idx_o, bus.gnt_oh_o, bus.req_ready_o);
    end
    step();
    checks++;
    if (dbg_ptr !== 3'd1) begin
      errors++;
      $display("FAIL fallback_ptr1 ptr=%0d required 1", dbg_ptr);
    end
  endtask

  task automatic test_lock();
    drive(8'h12, 1'b0);
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (bus.gnt_oh_o !== 8'h02 || bus.gnt_idx_o !== 3'd1 || bus.req_ready_o !== 8'h00) begin
        errors++;
        $display("FAIL lock_stall_%0d oh=%h idx=%0d rdy=%h required 02 1 00",
                 c, bus.gnt_oh_o, bus.gnt_idx_o, bus.req_ready_o);
      end
      step();
    end
    checks++;
    if (dbg_state !== LockHeld || dbg_lock_oh !== 8'h02) begin
      errors++;
      $display("FAIL lock_held lock=%0d lock_oh=%h required 1 02", dbg_state, dbg_lock_oh);
    end
    drive(8'h13, 1'b0);
    checks++;
    if (bus.gnt_oh_o !== 8'h02 || dbg_state !== LockHeld) begin
      errors++;
      $display("FAIL lock_ignore_new oh=%h lock=%0d required 02 1", bus.gnt_oh_o, dbg_state);
    end
    step();
    drive(8'h13, 1'b1);
    checks++;
    if (bus.req_ready_o !== 8'h02 || bus.gnt_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL lock_accept rdy=%h valid=%b required 02 1", bus.req_ready_o, bus.gnt_valid_o);
    end
    step();
    checks++;
    if (dbg_ptr !== 3'd2 || dbg_state !== LockOpen || bus.gnt_idx_o !== 3'd4) begin
      errors++;
      $display("FAIL lock_after ptr=%0d lock=%0d idx=%0d required 2 0 4",
               dbg_ptr, dbg_state, bus.gnt_idx_o);
    end
  endtask

  task automatic test_drop();
    drive(8'h13, 1'b0);
    step();
    checks++;
    if (dbg_state !== LockHeld || dbg_lock_oh !== 8'h10 || dbg_ptr !== 3'd2) begin
      errors++;
      $display("FAIL drop_setup lock=%0d lock_oh=%h ptr=%0d required 1 10 2",
               dbg_state, dbg_lock_oh, dbg_ptr);
    end
    drive(8'h03, 1'b1);
    checks++;
    if (bus.gnt_valid_o !== 1'b0 || bus.gnt_oh_o !== 8'h00 || bus.gnt_idx_o !== 3'd0 ||
        bus.req_ready_o !== 8'h00) begin
      errors++;
      $display("FAIL drop_gap valid=%b oh=%h idx=%0d rdy=%h required 0 00 0 00",
               bus.gnt_valid_o, bus.gnt_oh_o, bus.gnt_idx_o, bus.req_ready_o);
    end
    step();
    checks++;
    if (dbg_state !== LockOpen || dbg_ptr !== 3'd2) begin
      errors++;
      $display("FAIL drop_release lock=%0d ptr=%0d required 0 2", dbg_state, dbg_ptr);
    end
    checks++;
    if (bus.gnt_idx_o !== 3'd0 || bus.gnt_oh_o !== 8'h01 || bus.req_ready_o !== 8'h01) begin
      errors++;
      $display("FAIL drop_rearb idx=%0d oh=%h rdy=%h required 0 01 01",
               bus.gnt_idx_o, bus.gnt_oh_o, bus.req_ready_o);
    end
    step();
  endtask

  task automatic test_reset_mid_lock();
    drive(8'h10, 1'b1);
    checks++;
    if (bus.gnt_idx_o !== 3'd4) begin
      errors++;
      $display("FAIL rml_setup_idx idx=%0d required 4", bus.gnt_idx_o);
    end
    step();
    drive(8'h20, 1'b0);
    step();
    checks++;
    if (dbg_state !== LockHeld || dbg_lock_oh !== 8'h20 || dbg_ptr !== 3'd5) begin
      errors++;
      $display("FAIL rml_locked lock=%0d lock_oh=%h ptr=%0d required 1 20 5",
               dbg_state, dbg_lock_oh, dbg_ptr);
    end
    drive(8'hA0, 1'b0);
    #1;
    rst_ni = 1'b0;
    #1;
    checks++;
    if (dbg_ptr !== 3'd0 || dbg_state !== LockOpen || bus.gnt_idx_o !== 3'd5 ||
        bus.gnt_oh_o !== 8'h20) begin
      errors++;
      $display("FAIL rml_async ptr=%0d lock=%0d idx=%0d oh=%h required 0 0 5 20",
               dbg_ptr, dbg_state, bus.gnt_idx_o, bus.gnt_oh_o);
    end
    rst_ni = 1'b1;
    drive(8'hA0, 1'b1);
    checks++;
    if (bus.req_ready_o !== 8'h20) begin
      errors++;
      $display("FAIL rml_accept rdy=%h required 20", bus.req_ready_o);
    end
    step();
    drive(8'hA0, 1'b0);
    checks++;
    if (dbg_ptr !== 3'd6 || bus.gnt_idx_o !== 3'd7) begin
      errors++;
      $display("FAIL rml_next ptr=%0d idx=%0d required 6 7", dbg_ptr, bus.gnt_idx_o);
    end
    step();
    drive(8'h00, 1'b0);
    step();
  endtask

  task automatic test_single();
    logic exp_rdy;
    for (int c = 0; c < 4; c++) begin
      exp_rdy = (c % 2 == 1) ? 1'b1 : 1'b0;
      bus1.req_valid_i = 1'b1;
      bus1.gnt_ready_i = exp_rdy;
      #1;
      checks++;
      if (bus1.gnt_oh_o !== 1'b1 || bus1.gnt_idx_o !== 1'b0 || bus1.gnt_valid_o !== 1'b1 ||
          bus1.req_ready_o !== exp_rdy || dbg_ptr1 !== 1'b0) begin
        errors++;
        $display("FAIL single_%0d oh=%b idx=%0d valid=%b rdy=%b ptr=%0d required 1 0 1 %b 0",
                 c, bus1.gnt_oh_o, bus1.gnt_idx_o, bus1.gnt_valid_o, bus1.req_ready_o,
                 dbg_ptr1, exp_rdy);
      end
      step();
    end
    bus1.req_valid_i = 1'b0;
    bus1.gnt_ready_i = 1'b1;
    #1;
    checks++;
    if (bus1.gnt_valid_o !== 1'b0 || bus1.gnt_oh_o !== 1'b0 || bus1.req_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL single_idle valid=%b oh=%b rdy=%b required 0 0 0",
               bus1.gnt_valid_o, bus1.gnt_oh_o, bus1.req_ready_o);
    end
  endtask

  // Sequence and final report
  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_rotate();
    test_fallback();
    test_lock();
    test_drop();
    test_reset_mid_lock();
    test_single();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_oh.md
Name: rr_arbiter_oh

Overview:
- N-input round-robin arbiter with valid/ready handshake on both sides.
- Produces a one-hot grant plus its binary index for the downstream mux and route-select logic in the NoC router input/output stages.
- Priority rotates past the winner on every completed handshake.
- An in-flight grant is locked so the one-hot vector stays stable while the downstream stalls.

Parameters:
- NumReq, 8, number of requesters; must be >= 1.
- LockGrant, 1, 1 = hold grant stable while gnt_valid_o && !gnt_ready_i; 0 = re-arbitrate every cycle.
- IdxWidth, derived (localparam), NumReq > 1 ? $clog2(NumReq) : 1.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- req_valid_i  in  NumReq  per-requester valid.
- req_ready_o  out  NumReq  per-requester ready; one-hot or zero.
- gnt_valid_o  out  1  a grant is being offered downstream.
- gnt_ready_i  in  1  downstream accepts the grant this cycle.
- gnt_oh_o  out  NumReq  one-hot grant vector; zero when gnt_valid_o=0.
- gnt_idx_o  out  IdxWidth  binary index of gnt_oh_o; 0 when gnt_valid_o=0.

Behaviour:
- State
  - ptr_q (IdxWidth): index of the highest-priority requester.
  - lock_q (1 bit).
  - lock_oh_q (NumReq).
  - Reset: ptr_q=0, lock_q=0, lock_oh_q=0.
- Outputs are combinational from state and inputs; zero-cycle latency from req_valid_i to grant.
  - Out of reset with req_valid_i=0: gnt_valid_o=0, gnt_oh_o=0, gnt_idx_o=0, req_ready_o=0.
- Arbitration when unlocked
  - mask = bits at positions >= ptr_q.
  - If (req_valid_i & mask) != 0, winner = lowest set bit of the masked vector.
  - Otherwise, winner = lowest set bit of req_valid_i.
  - gnt_valid_o = |req_valid_i.
- Locked (lock_q=1)
  - gnt_oh_o = lock_oh_q & req_valid_i.
  - gnt_valid_o = |(lock_oh_q & req_valid_i).
  - New requests arriving while locked are ignored until the lock releases.
- Index: gnt_idx_o = binary encoding of gnt_oh_o, via the OH2UInt cell.
- Ready: req_ready_o = gnt_oh_o & {NumReq{gnt_ready_i}}.
- Handshake (hs) = gnt_valid_o && gnt_ready_i.
  - On hs: ptr_q <= (gnt_idx_o == NumReq-1) ? 0 : gnt_idx_o+1; lock_q <= 0.
  - No handshake: ptr_q holds.
- Lock entry (LockGrant=1): gnt_valid_o && !gnt_ready_i && !lock_q -> lock_q <= 1, lock_oh_q <= gnt_oh_o.
- Lock release
  - On hs.
  - When the locked requester drops valid (protocol violation, tolerated): lock_q <= 0, no pointer update, and gnt_valid_o=0 that cycle.
  - Re-arbitration occurs the next cycle.
- LockGrant=0: lock_q is tied 0.
- Boundary cases
  - NumReq=1: ptr_q constant 0, gnt_oh_o = req_valid_i, gnt_idx_o = 0.
  - Wrap: ptr_q=NumReq-1 with only requester 0 valid -> requester 0 wins through the unmasked fallback.
  - Reset asserted mid-lock: state clears asynchronously; outputs follow the unlocked rules immediately.
- Invariants (SVA)
  - $onehot0(gnt_oh_o).
  - gnt_valid_o == |gnt_oh_o.
  - Grant stable while gnt_valid_o && !gnt_ready_i when LockGrant=1, unless the locked requester drops valid.

Decomposition:
- Shared package arb_pkg:
  - function idx_width(n) returning n > 1 ? $clog2(n) : 1.
  - function lowest_set_oh(vec), implemented as vec & (~vec + 1).
- Sub-modules:
  - Instantiate the existing OH2UInt cell for gnt_idx_o.
  - The masked priority pick is a natural sub-module, rr_prio_pick: inputs req, ptr; output one-hot winner. It is purely combinational.
  - The top module holds all registers.

Test Plan:
- Reset, then req_valid_i=8'hFF, gnt_ready_i=1 held for 8 cycles -> gnt_idx_o sequence 0,1,2,3,4,5,6,7, then wraps to 0; each cycle req_ready_o = 1<<idx.
- ptr_q=3 (after granting 2), req_valid_i=8'b0000_0101 -> winner idx 0 via fallback; next ptr_q=1.
- req_valid_i=8'h12, gnt_ready_i=0 for 3 cycles; then assert 8'h13 -> gnt_oh_o stays 8'h02 (idx 1) throughout; on gnt_ready_i=1, ptr_q=2 and the next winner is idx 4.
- Locked on idx 4, req_valid_i[4] deasserted -> gnt_valid_o=0 that cycle, lock cleared, ptr_q unchanged; the next cycle grants by round-robin from the old ptr.
- rst_ni pulsed low while locked on idx 5 with ptr_q=5 -> immediately ptr_q=0, lock cleared; with req_valid_i=8'hA0 the grant is idx 5 (lowest ≥0).
- NumReq=1 build: req_valid_i=1, gnt_ready_i toggling -> gnt_oh_o=1, gnt_idx_o=0, req_ready_o mirrors gnt_ready_i.
